ysyx_22050133_mdu: RTL

Iterative multiply/divide unit for the RV64M and RV32M-word instructions. It replaces the single-cycle `*`, `/` and `%` operators in the execute stage with a multi-cycle datapath that is parametrised in width. It also implements MULH, MULHSU and MULHU, which the execute stage has so far returned as 0. The unit sits beside the ALU in EX and uses a valid/ready handshake on both sides, so the pipeline stalls EX while the unit is busy.

---
 rtl/ysyx_22050133_mdu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050133_mdu.sv
// Iterative multiply/divide unit for RV64M / RV32M word ops.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Signs are fixed on the final iteration. Divide-by-zero and signed
// overflow resolve at accept without iterating.
module ysyx_22050133_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] N_FULL = CW'(XLEN);
    localparam logic [CW-1:0] N_WORD = CW'(32);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              word_q, mulhi_q, sign1_q, sign2_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;    // product, or partial remainder in the low half
    logic [2*XLEN-1:0] mcand;  // multiplicand, shifted left each step
    logic [XLEN-1:0]   opb;    // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0]   dvs;    // divisor magnitude

    // Extend a 32-bit value to XLEN, sign-extending only when sg is set.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sg);
        logic [XLEN-1:0] r;
        r = '0;
        r[31:0] = v;
        for (int i = 32; i < XLEN; i++) r[i] = sg & v[31];
        return r;
    endfunction

    logic            is_div, s1_signed, s2_signed, sign1, sign2, div0, ovf, fast;
    logic [XLEN-1:0] x1, x2, mag1, mag2, fast_res;

    // Operand prep: word truncation, magnitudes/signs and fast-path detection.
    always_comb begin
        is_div    = op[2];
        s1_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        s2_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        x1        = word ? ext32(src1[31:0], s1_signed) : src1;
        x2        = word ? ext32(src2[31:0], s2_signed) : src2;
        sign1     = s1_signed & (word ? src1[31] : src1[XLEN-1]);
        sign2     = s2_signed & (word ? src2[31] : src2[XLEN-1]);
        mag1      = sign1 ? -x1 : x1;
        mag2      = sign2 ? -x2 : x2;
        div0      = word ? (src2[31:0] == 32'd0) : (src2 == '0);
        ovf       = ((op == 3'd4) || (op == 3'd6)) &&
                    (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                          : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1));
        fast      = is_div && (div0 || ovf);
        // op[1] clear: quotient (DIV/DIVU); set: remainder (REM/REMU)
        if (!op[1]) fast_res = div0 ? '1 : src1;
        else        fast_res = div0 ? src1 : '0;
        if (word) fast_res = ext32(fast_res[31:0], 1'b1);
    end

    logic [2*XLEN-1:0] acc_nxt, mcand_nxt, prod;
    logic [XLEN-1:0]   opb_nxt, quo, rem, fin;
    logic [XLEN:0]     r2, diff;

    // One iteration step plus the sign-fixed result of the last step.
    always_comb begin
        acc_nxt   = acc;
        mcand_nxt = mcand;
        opb_nxt   = opb;
        r2        = {acc[XLEN-1:0], opb[XLEN-1]};
        diff      = r2 - {1'b0, dvs};
        if (op_q[2]) begin
            acc_nxt = {{XLEN{1'b0}}, diff[XLEN] ? r2[XLEN-1:0] : diff[XLEN-1:0]};
            opb_nxt = {opb[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_nxt   = acc + (opb[0] ? mcand : '0);
            mcand_nxt = mcand << 1;
            opb_nxt   = opb >> 1;
        end
        prod = (sign1_q ^ sign2_q) ? -acc_nxt : acc_nxt;
        quo  = (sign1_q ^ sign2_q) ? -opb_nxt : opb_nxt;
        rem  = sign1_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        if (op_q[2]) fin = op_q[1] ? rem : quo;
        else         fin = mulhi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        if (word_q) fin = ext32(fin[31:0], 1'b1);
    end

    assign in_ready = (state == IDLE);

    // Control FSM and datapath registers; flush and reset abort everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            opb       <= '0;
            dvs       <= '0;
            op_q      <= '0;
            word_q    <= 1'b0;
            mulhi_q   <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q    <= op;
                    word_q  <= word;
                    // word forms of MULH* collapse to MUL
                    mulhi_q <= !word && (op == 3'd1 || op == 3'd2 || op == 3'd3);
                    sign1_q <= sign1;
                    sign2_q <= sign2;
                    cnt     <= (word || XLEN == 32) ? N_WORD : N_FULL;
                    acc     <= '0;
                    mcand   <= {{XLEN{1'b0}}, mag1};
                    // word dividends are pre-aligned so their MSB leaves first
                    opb     <= is_div ? (word ? (mag1 << (XLEN - 32)) : mag1) : mag2;
                    dvs     <= mag2;
                    if (fast) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= fast_res;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    mcand <= mcand_nxt;
                    opb   <= opb_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= fin;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
